// File: rtl/memory_arbiter_pkg.sv
// Shared types and defaults for the CPU/IOP memory arbiter.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin tie break).
package memory_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W       = 17;
    localparam int unsigned DEF_DATA_W       = 32;
    localparam int unsigned DEF_LOCK_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_IOP = 1'b1
    } owner_t;

    function automatic owner_t other_owner(input owner_t o);
        return (o == OWNER_CPU) ? OWNER_IOP : OWNER_CPU;
    endfunction

endpackage

// File: rtl/memory_arbiter_arb_pick.sv
// Combinational winner selection for the memory arbiter.
// ARB_ROUND_ROBIN_EN: ties go to the requester not served last;
// otherwise fixed priority IOP > CPU.
module memory_arbiter_arb_pick
    import memory_arbiter_pkg::*;
(
    input  logic   i_cpu_req,
    input  logic   i_iop_req,
    input  logic   i_lock_valid,
    input  owner_t i_lock_owner,
`ifdef ARB_ROUND_ROBIN_EN
    input  owner_t i_rr_last,
`endif
    output logic   o_valid,
    output owner_t o_owner
);

    // Only the lock holder is eligible while a lock is held; otherwise resolve ties
    always_comb begin
        o_valid = 1'b0;
        o_owner = OWNER_CPU;
        if (i_lock_valid) begin
            o_owner = i_lock_owner;
            o_valid = (i_lock_owner == OWNER_IOP) ? i_iop_req : i_cpu_req;
        end else if (i_cpu_req && i_iop_req) begin
            o_valid = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            o_owner = other_owner(i_rr_last);
`else
            o_owner = OWNER_IOP;
`endif
        end else if (i_iop_req) begin
            o_valid = 1'b1;
            o_owner = OWNER_IOP;
        end else if (i_cpu_req) begin
            o_valid = 1'b1;
            o_owner = OWNER_CPU;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares a single-port memory between CPU and IOP with req/ack handshakes,
// 3-cycle accesses (IDLE/ACCESS/DONE) and locked read-modify-write support.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin tie break).
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_lock,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              iop_req,
    input  logic              iop_we,
    input  logic              iop_lock,
    input  logic [ADDR_W-1:0] iop_addr,
    input  logic [DATA_W-1:0] iop_wdata,
    output logic              iop_ack,
    output logic [DATA_W-1:0] iop_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lock_timeout
);

    localparam int unsigned CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    state_t            r_state;
    state_t            w_state_next;
    owner_t            r_owner;
    logic              r_owner_we;
    logic              r_owner_lock;
    logic              r_lock_valid;
    owner_t            r_lock_owner;
    logic [CNT_W-1:0]  r_lock_cnt;
    logic              r_lock_timeout;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_iop_rdata;
    logic              w_grant_valid;
    owner_t            w_grant_owner;
    logic              w_holder_req;
`ifdef ARB_ROUND_ROBIN_EN
    owner_t            r_rr_last;
`endif

    memory_arbiter_arb_pick u_pick (
        .i_cpu_req    (cpu_req),
        .i_iop_req    (iop_req),
        .i_lock_valid (r_lock_valid),
        .i_lock_owner (r_lock_owner),
`ifdef ARB_ROUND_ROBIN_EN
        .i_rr_last    (r_rr_last),
`endif
        .o_valid      (w_grant_valid),
        .o_owner      (w_grant_owner)
    );

    assign w_holder_req = (r_lock_owner == OWNER_IOP) ? iop_req : cpu_req;
    assign cpu_rdata    = r_cpu_rdata;
    assign iop_rdata    = r_iop_rdata;
    assign lock_timeout = r_lock_timeout;

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Next state: leave IDLE only on a grant, then ACCESS and DONE take one cycle each
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_grant_valid) w_state_next = ST_ACCESS;
            ST_ACCESS: w_state_next = ST_DONE;
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Outputs: memory bus only in ACCESS, ack only in DONE; everything quiet under reset
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        cpu_ack   = 1'b0;
        iop_ack   = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_ACCESS: begin
                    mem_we = r_owner_we;
                    if (r_owner == OWNER_IOP) begin
                        mem_addr  = iop_addr;
                        mem_wdata = iop_wdata;
                    end else begin
                        mem_addr  = cpu_addr;
                        mem_wdata = cpu_wdata;
                    end
                end
                ST_DONE: begin
                    cpu_ack = (r_owner == OWNER_CPU);
                    iop_ack = (r_owner == OWNER_IOP);
                end
                default: ;
            endcase
        end
    end

    // Latch owner and its command attributes at grant time
    always_ff @(posedge clock) begin
        if (reset) begin
            r_owner      <= OWNER_CPU;
            r_owner_we   <= 1'b0;
            r_owner_lock <= 1'b0;
        end else if (r_state == ST_IDLE && w_grant_valid) begin
            r_owner      <= w_grant_owner;
            r_owner_we   <= (w_grant_owner == OWNER_IOP) ? iop_we : cpu_we;
            r_owner_lock <= (w_grant_owner == OWNER_IOP) ? iop_lock : cpu_lock;
        end
    end

    // Lock bookkeeping: set/clear on completion, revoke after LOCK_TIMEOUT idle holder cycles
    always_ff @(posedge clock) begin
        if (reset) begin
            r_lock_valid   <= 1'b0;
            r_lock_owner   <= OWNER_CPU;
            r_lock_cnt     <= '0;
            r_lock_timeout <= 1'b0;
        end else begin
            r_lock_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_lock_cnt <= '0;
                    end else if (r_lock_valid && !w_holder_req) begin
                        if (r_lock_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                            r_lock_valid   <= 1'b0;
                            r_lock_cnt     <= '0;
                            r_lock_timeout <= 1'b1;
                        end else begin
                            r_lock_cnt <= r_lock_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_lock_valid <= r_owner_lock;
                    r_lock_owner <= r_owner;
                    r_lock_cnt   <= '0;
                end
                default: ;
            endcase
        end
    end

    // Capture read data on the edge that ends ACCESS; writes leave it untouched
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cpu_rdata <= '0;
            r_iop_rdata <= '0;
        end else if (r_state == ST_ACCESS && !r_owner_we) begin
            if (r_owner == OWNER_IOP) r_iop_rdata <= mem_rdata;
            else                      r_cpu_rdata <= mem_rdata;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Remember who was served last; a locked sequence keeps the same owner so counts once
    always_ff @(posedge clock) begin
        if (reset)                  r_rr_last <= OWNER_IOP;
        else if (r_state == ST_DONE) r_rr_last <= r_owner;
    end
`endif

endmodule
